ram_read_requester: RTL and testbench



---
 rtl/ram_read_requester.sv | 153 +++++++++++++++
 tb/tb_ram_read_requester.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_requester.sv
// Read requester for ram_controller: issues hash hits, captures returned bursts in a FWFT FIFO.
// Optional WAIT timeout abort is enabled by defining RAM_REQ_TIMEOUT_EN.
module ram_read_requester #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned SEQ_WIDTH  = 3,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic [SEQ_WIDTH-1:0]    req_seq_in,
    input  logic [ADDR_WIDTH-4:0]   req_idx_in,
    output logic [SEQ_WIDTH-1:0]    hash_pack_seq_out,
    output logic [ADDR_WIDTH-1:0]   hash_addr_offset_out,
    output logic                    hash_hit_out,
    input  logic                    rd_data_valid_in,
    input  logic [DATA_WIDTH-1:0]   rd_data_in,
    output logic                    m_valid_out,
    input  logic                    m_ready_in,
    output logic [DATA_WIDTH-1:0]   m_data_out,
    output logic [SEQ_WIDTH-1:0]    m_seq_out,
    output logic                    m_last_out,
    output logic                    busy_out,
    output logic                    stray_err_out,
    output logic                    timeout_err_out
);
    localparam int unsigned CNT_W = $clog2(BURST_LEN);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef struct packed {
        logic [SEQ_WIDTH-1:0]  seq;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } ret_word_t;

    typedef enum logic [1:0] {IDLE, SETUP, HIT, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    ret_word_t        mem [FIFO_DEPTH];
    ret_word_t        head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count, count_nxt;
    logic             fifo_full, push, pop, stray, accept, last_word, timed_out;

`ifdef RAM_REQ_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    logic [TMR_W-1:0] timer;
`endif

    assign count       = wr_ptr - rd_ptr;
    assign fifo_full   = (count == PTR_W'(FIFO_DEPTH));
    assign m_valid_out = (count != '0);
    assign head        = mem[rd_ptr[AW-1:0]];
    // Data fields read as zero whenever nothing is valid, including in reset.
    assign m_data_out  = m_valid_out ? head.data : '0;
    assign m_seq_out   = m_valid_out ? head.seq  : '0;
    assign m_last_out  = m_valid_out ? head.last : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        stray     = 1'b0;
        timed_out = 1'b0;
        pop       = m_valid_out && m_ready_in;
        if (rd_data_valid_in) begin
            if (state == WAIT && !fifo_full) push  = 1'b1;
            else                             stray = 1'b1;
        end
        last_word = push && (word_cnt == CNT_W'(BURST_LEN - 1));
        case (state)
            IDLE: begin
                if (req_valid_in && req_ready_out) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = HIT;
            HIT:   state_nxt = WAIT;
            WAIT: begin
                if (last_word) begin
                    state_nxt = IDLE;
                end
`ifdef RAM_REQ_TIMEOUT_EN
                else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        count_nxt = count + PTR_W'(push) - PTR_W'(pop);
    end

    // Ready is precomputed from next state/occupancy so it is a clean register yet not a cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_out        <= 1'b0;
            hash_pack_seq_out    <= '0;
            hash_addr_offset_out <= '0;
            hash_hit_out         <= 1'b0;
            busy_out             <= 1'b0;
            stray_err_out        <= 1'b0;
            word_cnt             <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
        end else begin
            if (accept) begin
                hash_pack_seq_out    <= req_seq_in;
                hash_addr_offset_out <= {req_idx_in, 3'b000};
            end
            req_ready_out <= (state_nxt == IDLE) && (count_nxt <= PTR_W'(FIFO_DEPTH - BURST_LEN));
            hash_hit_out  <= (state_nxt == HIT);
            busy_out      <= (state_nxt != IDLE);
            if (stray) stray_err_out <= 1'b1;
            if (state == HIT) word_cnt <= '0;
            else if (push)    word_cnt <= word_cnt + CNT_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{seq: hash_pack_seq_out, last: last_word, data: rd_data_in};
    end

`ifdef RAM_REQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer           <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            if (state == HIT)       timer <= '0;
            else if (state == WAIT) timer <= timer + TMR_W'(1);
            if (timed_out) timeout_err_out <= 1'b1;
        end
    end
`else
    assign timeout_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_ram_read_requester.sv
// Directed self-checking bench for ram_read_requester with a small expected-word queue.
module tb_ram_read_requester;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_in, req_ready_out;
    logic [2:0]  req_seq_in;
    logic [6:0]  req_idx_in;
    logic [2:0]  hash_pack_seq_out;
    logic [9:0]  hash_addr_offset_out;
    logic        hash_hit_out;
    logic        rd_data_valid_in;
    logic [63:0] rd_data_in;
    logic        m_valid_out, m_ready_in;
    logic [63:0] m_data_out;
    logic [2:0]  m_seq_out;
    logic        m_last_out, busy_out, stray_err_out, timeout_err_out;

    typedef struct packed {
        logic [2:0]  seq;
        logic        last;
        logic [63:0] data;
    } exp_word_t;

    exp_word_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    ram_read_requester dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_seq_in(req_seq_in), .req_idx_in(req_idx_in),
        .hash_pack_seq_out(hash_pack_seq_out), .hash_addr_offset_out(hash_addr_offset_out),
        .hash_hit_out(hash_hit_out),
        .rd_data_valid_in(rd_data_valid_in), .rd_data_in(rd_data_in),
        .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
        .m_data_out(m_data_out), .m_seq_out(m_seq_out), .m_last_out(m_last_out),
        .busy_out(busy_out), .stray_err_out(stray_err_out), .timeout_err_out(timeout_err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid_in = 1'b0; req_seq_in = '0; req_idx_in = '0;
        rd_data_valid_in = 1'b0; rd_data_in = '0; m_ready_in = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic [2:0] s, input logic [6:0] idx);
        int n = 0;
        req_valid_in = 1'b1; req_seq_in = s; req_idx_in = idx;
        while (!req_ready_out && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_wait", 64'(n < 100), 64'(1));
        tick();
        req_valid_in = 1'b0;
    endtask

    // Leaves the bench in the first WAIT cycle.
    task automatic wait_hit();
        int n = 0;
        while (!hash_hit_out && n < 8) begin
            tick();
            n++;
        end
        check("hit_wait", 64'(n < 8), 64'(1));
        tick();
    endtask

    task automatic send_words(input logic [2:0] s, input logic [63:0] base, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            rd_data_valid_in = 1'b1;
            rd_data_in = base + 64'(first + i);
            exp_q.push_back('{seq: s, last: (first + i == 7), data: base + 64'(first + i)});
            tick();
        end
        rd_data_valid_in = 1'b0;
    endtask

    task automatic drain_n(input int n, input bit chk_ready);
        exp_word_t e;
        int w;
        m_ready_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!m_valid_out && w < 50) begin
                tick();
                w++;
            end
            check("m_valid_wait", 64'(w < 50), 64'(1));
            if (exp_q.size() == 0) begin
                check("exp_queue_nonempty", 64'(0), 64'(1));
            end else begin
                e = exp_q.pop_front();
                if (chk_ready) check("ready_vs_free", 64'(req_ready_out), 64'(exp_q.size() + 1 <= 8));
                check("m_data", m_data_out, e.data);
                check("m_seq", 64'(m_seq_out), 64'(e.seq));
                check("m_last", 64'(m_last_out), 64'(e.last));
            end
            tick();
        end
        m_ready_in = 1'b0;
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        tick();
        check("rst_req_ready", 64'(req_ready_out), 64'(0));
        check("rst_m_valid", 64'(m_valid_out), 64'(0));
        check("rst_hit", 64'(hash_hit_out), 64'(0));
        check("rst_busy", 64'(busy_out), 64'(0));
        check("rst_offset", 64'(hash_addr_offset_out), 64'(0));
        check("rst_stray", 64'(stray_err_out), 64'(0));
        check("rst_timeout", 64'(timeout_err_out), 64'(0));
        reset = 1'b0;
        tick();
        check("post_rst_ready", 64'(req_ready_out), 64'(1));

        // Single request seq=2 idx=5
        do_req(3'd2, 7'd5);
        check("t1_offset", 64'(hash_addr_offset_out), 64'h028);
        check("t1_seq", 64'(hash_pack_seq_out), 64'(2));
        check("t1_setup_hit", 64'(hash_hit_out), 64'(0));
        check("t1_ready_low", 64'(req_ready_out), 64'(0));
        check("t1_busy", 64'(busy_out), 64'(1));
        tick();
        check("t1_hit_pulse", 64'(hash_hit_out), 64'(1));
        tick();
        check("t1_hit_end", 64'(hash_hit_out), 64'(0));
        check("t1_offset_hold", 64'(hash_addr_offset_out), 64'h028);
        send_words(3'd2, 64'h100, 0, 8);
        check("t1_idle", 64'(busy_out), 64'(0));
        check("t1_ready_again", 64'(req_ready_out), 64'(1));
        check("t1_fwft_head", m_data_out, 64'h100);
        drain_n(8, 1'b0);
        check("t1_empty", 64'(m_valid_out), 64'(0));

        // Two bursts with downstream stalled
        do_req(3'd1, 7'h10);
        wait_hit();
        send_words(3'd1, 64'h200, 0, 8);
        do_req(3'd3, 7'h11);
        check("t2_offset", 64'(hash_addr_offset_out), 64'h088);
        wait_hit();
        send_words(3'd3, 64'h300, 0, 8);
        check("t2_full_not_ready", 64'(req_ready_out), 64'(0));
        check("t2_not_busy", 64'(busy_out), 64'(0));
        drain_n(16, 1'b1);
        check("t2_empty", 64'(m_valid_out), 64'(0));

        // Stray word in IDLE
        rd_data_valid_in = 1'b1; rd_data_in = 64'hDEAD;
        tick();
        rd_data_valid_in = 1'b0;
        check("t3_stray", 64'(stray_err_out), 64'(1));
        check("t3_fifo_empty", 64'(m_valid_out), 64'(0));
        tick();
        check("t3_stray_sticky", 64'(stray_err_out), 64'(1));
        do_reset();

        // Short burst: only 5 words
        do_req(3'd4, 7'd2);
        wait_hit();
        send_words(3'd4, 64'h400, 0, 5);
`ifdef RAM_REQ_TIMEOUT_EN
        repeat (58) tick();
        check("t4_no_timeout_yet", 64'(timeout_err_out), 64'(0));
        check("t4_busy_yet", 64'(busy_out), 64'(1));
        tick();
        check("t4_timeout", 64'(timeout_err_out), 64'(1));
        check("t4_idle", 64'(busy_out), 64'(0));
        drain_n(5, 1'b0);
        check("t4_empty", 64'(m_valid_out), 64'(0));
        do_req(3'd5, 7'd3);
        wait_hit();
        send_words(3'd5, 64'h500, 0, 8);
        drain_n(8, 1'b0);
        check("t4_timeout_sticky", 64'(timeout_err_out), 64'(1));
`else
        repeat (70) tick();
        check("t4_no_timeout", 64'(timeout_err_out), 64'(0));
        check("t4_still_busy", 64'(busy_out), 64'(1));
`endif
        do_reset();

        // Reset during WAIT after 3 words
        do_req(3'd6, 7'd7);
        wait_hit();
        send_words(3'd6, 64'h600, 0, 3);
        reset = 1'b1;
        #1;
        check("t5_m_valid", 64'(m_valid_out), 64'(0));
        check("t5_busy", 64'(busy_out), 64'(0));
        check("t5_offset", 64'(hash_addr_offset_out), 64'(0));
        check("t5_seq", 64'(hash_pack_seq_out), 64'(0));
        check("t5_ready", 64'(req_ready_out), 64'(0));
        check("t5_m_data", m_data_out, 64'(0));
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("t5_ready_after", 64'(req_ready_out), 64'(1));
        check("t5_stray_clear", 64'(stray_err_out), 64'(0));
        do_req(3'd7, 7'd1);
        wait_hit();
        send_words(3'd7, 64'h700, 0, 8);
        drain_n(8, 1'b0);

        // Simultaneous push/pop with 15 words held
        do_req(3'd1, 7'h20);
        wait_hit();
        send_words(3'd1, 64'h800, 0, 8);
        do_req(3'd2, 7'h21);
        wait_hit();
        send_words(3'd2, 64'h880, 0, 7);
        check("t6_head", m_data_out, 64'h800);
        rd_data_valid_in = 1'b1; rd_data_in = 64'h887; m_ready_in = 1'b1;
        exp_q.push_back('{seq: 3'd2, last: 1'b1, data: 64'h887});
        void'(exp_q.pop_front());
        tick();
        rd_data_valid_in = 1'b0; m_ready_in = 1'b0;
        check("t6_no_stray", 64'(stray_err_out), 64'(0));
        check("t6_idle", 64'(busy_out), 64'(0));
        check("t6_ready_low", 64'(req_ready_out), 64'(0));
        check("t6_new_head", m_data_out, 64'h801);
        drain_n(15, 1'b0);
        check("t6_count15_empty", 64'(m_valid_out), 64'(0));
        for (int b = 0; b < 3; b++) begin
            do_req(3'(b + 3), 7'(b + 40));
            wait_hit();
            send_words(3'(b + 3), 64'h900 + 64'(b * 16), 0, 8);
            drain_n(8, 1'b0);
        end
        check("t6_wrap_empty", 64'(m_valid_out), 64'(0));
        check("t6_final_stray", 64'(stray_err_out), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
